// File: rtl/id_rf_hazard.sv
// Decode-stage register file (8 x 16) with write-before-read bypass, plus
// load-use hazard detection and a saturating count of inserted bubbles.
module id_rf_hazard (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rd_reg_1,
    input  logic [2:0]  rd_reg_2,
    input  logic        uses_Rs,
    input  logic        has_Rt,
    input  logic        wr_en,
    input  logic [2:0]  wr_reg,
    input  logic [15:0] wr_data,
    input  logic        ex_mem_en,
    input  logic        ex_mem_wr,
    input  logic        ex_wr_en,
    input  logic [2:0]  ex_wr_reg,
    input  logic        mem_stall_n,
    input  logic        take_new_PC,
    output logic [15:0] rd_data_1,
    output logic [15:0] rd_data_2,
    output logic        hazard_stall_n,
    output logic [15:0] stall_count,
    output logic        err
);

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [15:0] regs [8];

    logic ex_load;
    logic rs_hit;
    logic rt_hit;
    logic load_use;
    logic count_en;

    // Register file: R0 is an ordinary register, writes ignore mem_stall_n
    // because re-writing held WB data is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_reg] <= wr_data;
        end
    end

    always_comb begin
        rd_data_1 = regs[rd_reg_1];
        if (wr_en && (wr_reg == rd_reg_1)) begin
            rd_data_1 = wr_data;
        end
    end

    always_comb begin
        rd_data_2 = regs[rd_reg_2];
        if (wr_en && (wr_reg == rd_reg_2)) begin
            rd_data_2 = wr_data;
        end
    end

    // Only loads need a bubble; stores and ALU producers are forwarded.
    assign ex_load  = ex_mem_en & ~ex_mem_wr & ex_wr_en;
    assign rs_hit   = uses_Rs & (ex_wr_reg == rd_reg_1);
    assign rt_hit   = has_Rt  & (ex_wr_reg == rd_reg_2);
    assign load_use = ex_load & (rs_hit | rt_hit) & ~take_new_PC;

    assign hazard_stall_n = ~load_use;

    // A memory stall freezes ID/EX, so the same hazard is seen repeatedly;
    // count it only on the cycle the pipeline actually advances.
    assign count_en = load_use & mem_stall_n & (stall_count != COUNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (count_en) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    assign err = (^{rd_reg_1, rd_reg_2, uses_Rs, has_Rt, wr_en, wr_reg, wr_data,
                    ex_mem_en, ex_mem_wr, ex_wr_en, ex_wr_reg,
                    mem_stall_n, take_new_PC}) === 1'bx;

endmodule

// File: doc/id_rf_hazard.md
ID_RF_HAZARD -- requirements
Module: id_rf_hazard

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: rd_reg_1  in  3  Rs index of the instruction in ID.
REQ-004 SHALL have: rd_reg_2  in  3  Rt index of the instruction in ID.
REQ-005 SHALL have: uses_Rs  in  1  instruction in ID reads Rs.
REQ-006 SHALL have: has_Rt  in  1  instruction in ID reads Rt.
REQ-007 SHALL have: wr_en, wr_reg, wr_data  in  1/3/16  writeback port from WB.
REQ-008 SHALL have: ex_mem_en, ex_mem_wr, ex_wr_en, ex_wr_reg  in  1/1/1/3  control of the instruction currently held in the ID/EX register.
REQ-009 SHALL have: mem_stall_n  in  1  low while memory stalls the pipeline; take_new_PC  in  1  redirect, squashes the ID instruction.
REQ-010 SHALL have: rd_data_1, rd_data_2  out  16  operand values; hazard_stall_n  out  1  low = insert bubble into ID/EX, hold IF/ID and PC.
REQ-011 SHALL have: stall_count  out  16  saturating count of load-use bubbles; err  out  1  X detected on any input.

Function
REQ-012 SHALL hold 8 x 16-bit registers R0..R7; R0 is an ordinary writable register.
REQ-013 SHALL write wr_data into R[wr_reg] on a rising edge when wr_en=1, regardless of mem_stall_n (repeated write of held WB data is harmless).
REQ-014 SHALL return R[rd_reg_1]/R[rd_reg_2] combinationally on rd_data_1/rd_data_2.
REQ-015 SHALL bypass: when wr_en=1 and wr_reg equals a read index, that read port outputs wr_data in the same cycle (write-before-read); both ports bypass independently.
REQ-016 SHALL define ex_load = ex_mem_en & ~ex_mem_wr & ex_wr_en.
REQ-017 SHALL drive hazard_stall_n=0 iff ex_load & ((uses_Rs & ex_wr_reg==rd_reg_1) | (has_Rt & ex_wr_reg==rd_reg_2)) & ~take_new_PC; otherwise 1.
REQ-018 SHALL NOT stall on store-in-EX (ex_mem_wr=1) or on non-load ALU producers; those are covered by forwarding.
REQ-019 SHALL produce exactly one bubble per load-use pair: the cycle after stall the bubble (wr_en=0) occupies ID/EX, so REQ-017 deasserts naturally.
REQ-020 SHALL, while mem_stall_n=0, keep hazard_stall_n evaluated combinationally but not count it; ID/EX holds, so the condition persists unchanged.
REQ-021 SHALL increment stall_count on a rising edge iff hazard_stall_n=0 & mem_stall_n=1; SHALL saturate at 16'hFFFF.
REQ-022 SHALL drive err=1 when any input other than clk/rst is X/Z (=== 1'bX reduction), else 0.
REQ-023 SHALL give take_new_PC priority over a simultaneous hazard: hazard_stall_n=1, no count.

Reset
REQ-024 SHALL, while rst=1, clear R0..R7 to 16'h0000 and stall_count to 0 asynchronously; writes during reset are ignored.
REQ-025 SHALL, after reset, output rd_data_1=rd_data_2=16'h0000 (absent bypass), hazard_stall_n=1 with control inputs low.
REQ-026 SHALL, on reset mid-stall, return hazard_stall_n to its combinational value and stall_count to 0 immediately.

Verification
REQ-027 Write R3=16'hBEEF (wr_en=1) then read rd_reg_1=3 next cycle -> rd_data_1=16'hBEEF; same-cycle read of R3 with wr_data=16'h1234 -> 16'h1234 on both ports if both index 3.
REQ-028 ex_load with ex_wr_reg=2, rd_reg_2=2, has_Rt=1 -> hazard_stall_n=0 for one cycle, stall_count 0->1; with has_Rt=0 -> no stall.
REQ-029 Same hazard with ex_mem_wr=1 (store) or ex_mem_en=0 -> hazard_stall_n=1, count unchanged.
REQ-030 Load-use hazard with mem_stall_n=0 for 3 cycles then 1 -> hazard_stall_n=0 throughout, stall_count increments once only.
REQ-031 Load-use hazard with take_new_PC=1 -> hazard_stall_n=1, no count; force stall_count to 16'hFFFF via 65535 stalls -> remains 16'hFFFF on next stall.
REQ-032 Assert rst asynchronously mid-cycle after writes -> all registers read 0, stall_count=0 before next edge; drive wr_reg=X -> err=1.
